mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arb_rr.sv | 35 +++
 rtl/mem_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//
// Purpose:
//   Shared definitions for the two-port memory arbiter: the arbiter FSM state
//   encoding, the port index constants and the default memory word width.
//
// Contents:
//   arb_state_t              FSM states IDLE / START / WAIT / DONE
//   PORT_IF, PORT_D          port indices (0 = instruction fetch, 1 = data)
//   DEFAULT_DATA_SIZE_BYTES  default memory word width in bytes
//   is_port_write()          true when a grant turns into a memory write
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // One state per phase of a memory transaction: waiting for a requester,
  // strobing the memory, waiting for the memory to finish, acknowledging.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEFAULT_DATA_SIZE_BYTES = 4;

  // Only the data port is able to write; the fetch port is read-only, so a
  // fetch grant never produces a write regardless of what d_we happens to be.
  function automatic logic is_port_write(input logic port, input logic we);
    return (port == PORT_D) && we;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
//
// Purpose:
//   Two-way round-robin picker. Purely combinational: given the current
//   requests and the port that won the previous grant, it names the port
//   that should win now. The caller decides when to latch the result.
//
// Ports:
//   req         in   2  request vector, bit 0 = fetch port, bit 1 = data port
//   last_grant  in   1  index of the port granted most recently
//   grant       out  1  index of the port that wins this arbitration
// -----------------------------------------------------------------------------
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  // A lone requester always wins. On a tie the port that did not win last
  // time gets the memory, which gives strict alternation while both ports
  // keep requesting. With no request at all the output is a don't-care and
  // defaults to the fetch port.
  always_comb begin
    grant = PORT_IF;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one slow, single-transaction memory between an instruction fetch
//   port (port 0, read only) and a data port (port 1, read/write). A four
//   state FSM (IDLE, START, WAIT, DONE) runs one memory operation at a time.
//   Ties between the ports are broken round-robin by mem_arb_rr.
//
//   Transaction timeline with a 5-cycle memory, request seen in IDLE in
//   cycle 0: memory_start in cycle 1, WAIT from cycle 2, ack in cycle 8,
//   next grant possible in cycle 9.
//
// Configuration:
//   MEM_ARB_TIMEOUT_EN  when defined, a counter runs while in WAIT; after
//                       TIMEOUT_CYCLES cycles without memory_rdy the
//                       operation is aborted: ack pulses with err=1 and the
//                       captured read data forced to zero. When undefined,
//                       WAIT only exits on memory_rdy and err is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES   WAIT cycles before abort (timeout build only)
//   DATA_SIZE_BYTES  memory word width in bytes, W = 8*DATA_SIZE_BYTES
//
// Ports:
//   clk                  in     1   clock, all state changes on posedge
//   reset_n              in     1   asynchronous active-low reset
//   if_req               in     1   fetch read request, held until if_ack
//   if_addr              in     32  fetch byte address
//   if_rdata             out    W   fetch read data, valid while if_ack
//   if_ack               out    1   fetch one-cycle completion pulse
//   d_req                in     1   data request, held until d_ack
//   d_we                 in     1   data write enable (1 = write)
//   d_addr               in     32  data byte address
//   d_wdata              in     W   data write data
//   d_rdata              out    W   data read data, valid while d_ack
//   d_ack                out    1   data one-cycle completion pulse
//   err                  out    1   timeout flag, valid with the ack pulse
//   memory_start         out    1   start strobe to the memory
//   memory_rdy           in     1   memory idle / operation finished
//   memory_write_enable  out    1   write select to the memory
//   memory_address       out    32  address to the memory
//   memory_data          inout  W   shared memory data bus
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 15,
  parameter int DATA_SIZE_BYTES = DEFAULT_DATA_SIZE_BYTES
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic                         if_req,
  input  logic [31:0]                  if_addr,
  output logic [8*DATA_SIZE_BYTES-1:0] if_rdata,
  output logic                         if_ack,

  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [31:0]                  d_addr,
  input  logic [8*DATA_SIZE_BYTES-1:0] d_wdata,
  output logic [8*DATA_SIZE_BYTES-1:0] d_rdata,
  output logic                         d_ack,

  output logic                         err,

  output logic                         memory_start,
  input  logic                         memory_rdy,
  output logic                         memory_write_enable,
  output logic [31:0]                  memory_address,
  inout  wire  [8*DATA_SIZE_BYTES-1:0] memory_data
);

  localparam int W = 8 * DATA_SIZE_BYTES;

  arb_state_t     state;
  arb_state_t     state_next;

  logic           rr_grant;
  logic           last_grant;
  logic           gnt_port;
  logic [31:0]    addr_q;
  logic           we_q;
  logic [W-1:0]   wdata_q;

  logic           grant_fire;
  logic           drive_bus;
  logic           timeout_exit;
  logic           capture;
  logic [W-1:0]   capture_data;
  logic           tmo_hit;

  mem_arb_rr u_rr (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .grant      (rr_grant)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  // The counter only needs to reach TIMEOUT_CYCLES-1, so size it for that.
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // The counter reads 0 in the first WAIT cycle, so it hits TIMEOUT_CYCLES-1
  // in the last allowed WAIT cycle and the FSM lands in DONE exactly
  // TIMEOUT_CYCLES cycles after entering WAIT. It is cleared in every other
  // state so each operation starts with a fresh budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state == ST_WAIT) && !memory_rdy && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // err is registered on the WAIT->DONE transition so it is high exactly
  // while the ack pulse is high and drops again when DONE returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_exit;
    end
  end

  assign err = err_q;
`else
  // Without the timeout feature WAIT can only be left through memory_rdy.
  // TIMEOUT_CYCLES stays in the parameter list so both builds share one
  // instantiation template.
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign err                = 1'b0;
`endif

  // State register. Reset drops any operation in flight without an ack; the
  // FSM then sits in IDLE until the memory reports ready again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode. A grant only happens when the memory is
  // idle, so a memory still busy with an abandoned operation holds requests
  // off. The bus is driven only through START and WAIT of a write so that
  // the memory can sample it; DONE already has it released.
  always_comb begin
    state_next   = state;
    grant_fire   = 1'b0;
    drive_bus    = 1'b0;
    memory_start = 1'b0;
    timeout_exit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memory_rdy && (if_req || d_req)) begin
          state_next = ST_START;
          grant_fire = 1'b1;
        end
      end
      ST_START: begin
        memory_start = 1'b1;
        drive_bus    = we_q;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        drive_bus = we_q;
        if (memory_rdy) begin
          state_next = ST_DONE;
        end else if (tmo_hit) begin
          state_next   = ST_DONE;
          timeout_exit = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Everything the memory sees is latched at grant time, so the requester
  // may change or drop its inputs once granted without disturbing the
  // operation. last_grant resets to the data port so the fetch port wins the
  // very first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT_D;
      gnt_port   <= PORT_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else if (grant_fire) begin
      last_grant <= rr_grant;
      gnt_port   <= rr_grant;
      addr_q     <= (rr_grant == PORT_D) ? d_addr : if_addr;
      we_q       <= is_port_write(rr_grant, d_we);
      if (rr_grant == PORT_D) begin
        wdata_q <= d_wdata;
      end
    end
  end

  // On a timeout the bus holds nothing meaningful, so zero is returned
  // instead of whatever happens to be floating on it.
  assign capture      = (state == ST_WAIT) && (state_next == ST_DONE);
  assign capture_data = timeout_exit ? '0 : memory_data;

  // Read data is captured only into the granted port and otherwise holds its
  // last value, so each port sees a stable word between its own acks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (capture) begin
      if (gnt_port == PORT_IF) begin
        if_rdata <= capture_data;
      end else begin
        d_rdata <= capture_data;
      end
    end
  end

  assign if_ack              = (state == ST_DONE) && (gnt_port == PORT_IF);
  assign d_ack               = (state == ST_DONE) && (gnt_port == PORT_D);
  assign memory_address      = addr_q;
  assign memory_write_enable = we_q;
  assign memory_data         = drive_bus ? wdata_q : {W{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. A behavioural 5-cycle memory sits on
//   the memory side; stimulus pushes the expected ack (port, data, err, cycle)
//   into a scoreboard queue and a negedge monitor pops and compares whenever
//   an ack appears. Build with +define+MEM_ARB_TIMEOUT_EN to exercise the
//   timeout path instead of the stuck-in-WAIT path.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [31:0]   if_addr;
  logic [W-1:0]  if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [W-1:0]  d_wdata;
  logic [W-1:0]  d_rdata;
  logic          d_ack;
  logic          err;
  logic          memory_start;
  logic          memory_rdy = 1'b1;
  logic          memory_write_enable;
  logic [31:0]   memory_address;
  wire  [W-1:0]  memory_data;

  logic          mem_drive = 1'b0;
  logic [W-1:0]  mem_out   = '0;
  logic          stall     = 1'b0;
  logic          loaded    = 1'b0;
  logic          op_we     = 1'b0;
  logic [31:0]   op_addr   = '0;
  int            busy      = 0;
  logic [W-1:0]  mem [0:63];

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;

  assign memory_data = mem_drive ? mem_out : {W{1'bz}};

  mem_arbiter #(
    .TIMEOUT_CYCLES  (15),
    .DATA_SIZE_BYTES (4)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .if_req              (if_req),
    .if_addr             (if_addr),
    .if_rdata            (if_rdata),
    .if_ack              (if_ack),
    .d_req               (d_req),
    .d_we                (d_we),
    .d_addr              (d_addr),
    .d_wdata             (d_wdata),
    .d_rdata             (d_rdata),
    .d_ack               (d_ack),
    .err                 (err),
    .memory_start        (memory_start),
    .memory_rdy          (memory_rdy),
    .memory_write_enable (memory_write_enable),
    .memory_address      (memory_address),
    .memory_data         (memory_data)
  );

  always #5 clk = ~clk;

  // Cycle number: incremented on every rising edge, read #1 later or at the
  // falling edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Behavioural slow memory. A start keeps memory_rdy low for five cycles;
  // a read drives its word for the one cycle in which memory_rdy returns.
  // Writes take the bus value at the start strobe. While 'stall' is set the
  // memory never finishes.
  always @(posedge clk) begin
    mem_drive <= 1'b0;
    if (!loaded) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= '0;
      end
      mem[4] <= 32'h1122_3344;
      loaded <= 1'b1;
    end else if (memory_start) begin
      op_we   <= memory_write_enable;
      op_addr <= memory_address;
      if (memory_write_enable) begin
        mem[memory_address[7:2]] <= memory_data;
      end
      busy       <= 5;
      memory_rdy <= 1'b0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if ((busy == 1) && !stall) begin
      busy       <= 0;
      memory_rdy <= 1'b1;
      if (!op_we) begin
        mem_drive <= 1'b1;
        mem_out   <= mem[op_addr[7:2]];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic expectAck(input logic port, input logic [31:0] rdata,
                           input logic errv, input int at_cyc);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = errv;
    e.cyc   = at_cyc;
    sb.push_back(e);
  endtask

  // Raises a request just after a rising edge so the arbiter samples it on
  // the next edge; returns the cycle number of that IDLE cycle.
  task automatic applyStimulus(input logic port, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int issue);
    @(posedge clk);
    #1;
    if (port == PORT_IF) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
    end
    issue = cyc;
  endtask

  // Waits (bounded) for the given port's ack; optionally drops that port's
  // request in the ack cycle, as a real requester would.
  task automatic waitAck(input logic port, input int budget, input bit drop);
    logic seen;
    seen = 1'b0;
    for (int i = 0; (i < budget) && !seen; i++) begin
      @(negedge clk);
      if ((port == PORT_D) ? d_ack : if_ack) seen = 1'b1;
    end
    if (drop) begin
      if (port == PORT_D) d_req = 1'b0;
      else                if_req = 1'b0;
    end
    checkOutput($sformatf("ack_seen_port%0d", port), {31'b0, seen}, 32'd1);
  endtask

  // Scoreboard monitor: every ack must match the oldest expectation in port,
  // data, err and cycle; an ack with nothing expected is an error, which also
  // catches acks lasting more than one cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (memory_start) begin
      checkOutput("start_when_ready", {31'b0, memory_rdy}, 32'd1);
    end
    if (if_ack || d_ack) begin
      checkOutput("single_ack", {31'b0, if_ack & d_ack}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_ack: got if_ack=%0b d_ack=%0b, expected none (cycle %0d)",
                 if_ack, d_ack, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_port", {31'b0, d_ack}, {31'b0, e.port});
        checkOutput("ack_rdata", (e.port == PORT_D) ? d_rdata : if_rdata, e.rdata);
        checkOutput("ack_err", {31'b0, err}, {31'b0, e.err});
        checkOutput("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int m;

    reset_n = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_if_ack", {31'b0, if_ack}, 32'd0);
    checkOutput("rst_d_ack", {31'b0, d_ack}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_mem_start", {31'b0, memory_start}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, memory_write_enable}, 32'd0);
    checkOutput("rst_mem_addr", memory_address, 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);
    reset_n = 1'b1;

    // Fetch read of 0x10: start in cycle 1, ack in cycle 8.
    applyStimulus(PORT_IF, 1'b0, 32'h10, 32'h0, n);
    expectAck(PORT_IF, 32'h1122_3344, 1'b0, n + 8);
    @(posedge clk);
    #1;
    checkOutput("fetch_start", {31'b0, memory_start}, 32'd1);
    checkOutput("fetch_addr", memory_address, 32'h10);
    checkOutput("fetch_we", {31'b0, memory_write_enable}, 32'd0);
    waitAck(PORT_IF, 20, 1'b1);

    // Data write of 0xDEADBEEF to 0x20, bus released in DONE, then read back.
    applyStimulus(PORT_D, 1'b1, 32'h20, 32'hDEAD_BEEF, n);
    expectAck(PORT_D, 32'hDEAD_BEEF, 1'b0, n + 8);
    @(posedge clk);
    #1;
    checkOutput("write_we", {31'b0, memory_write_enable}, 32'd1);
    checkOutput("write_addr", memory_address, 32'h20);
    waitAck(PORT_D, 20, 1'b1);
    tests++;
    if (memory_data === 32'hDEAD_BEEF) begin
      fails++;
      $display("[TB] FAIL bus_released: got 0x%08h on memory_data, expected high-Z", memory_data);
    end
    applyStimulus(PORT_D, 1'b0, 32'h20, 32'h0, n);
    expectAck(PORT_D, 32'hDEAD_BEEF, 1'b0, n + 8);
    waitAck(PORT_D, 20, 1'b1);

    // Both ports requesting from reset: port 0, port 1, port 0, 9 cycles apart.
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h20;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = cyc;
    expectAck(PORT_IF, 32'h1122_3344, 1'b0, n + 8);
    expectAck(PORT_D, 32'hDEAD_BEEF, 1'b0, n + 17);
    expectAck(PORT_IF, 32'h1122_3344, 1'b0, n + 26);
    waitAck(PORT_IF, 20, 1'b0);
    waitAck(PORT_D, 20, 1'b0);
    waitAck(PORT_IF, 20, 1'b0);
    if_req = 1'b0;
    d_req  = 1'b0;

    // Short d_req pulse while port 0 is busy is ignored; if_req dropped after
    // grant still completes.
    applyStimulus(PORT_IF, 1'b0, 32'h10, 32'h0, n);
    expectAck(PORT_IF, 32'h1122_3344, 1'b0, n + 8);
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h20;
    @(posedge clk);
    #1;
    d_req = 1'b0;
    waitAck(PORT_IF, 20, 1'b0);
    repeat (15) @(negedge clk);
    checkOutput("pulse_no_start", {31'b0, memory_start}, 32'd0);

    // Reset while in WAIT: outputs clear at once, no ack, and a new request
    // waits for the still-busy memory.
    stall = 1'b1;
    applyStimulus(PORT_IF, 1'b0, 32'h10, 32'h0, n);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("wrst_mem_start", {31'b0, memory_start}, 32'd0);
    checkOutput("wrst_mem_addr", memory_address, 32'd0);
    checkOutput("wrst_mem_we", {31'b0, memory_write_enable}, 32'd0);
    checkOutput("wrst_if_ack", {31'b0, if_ack}, 32'd0);
    checkOutput("wrst_if_rdata", if_rdata, 32'd0);
    checkOutput("wrst_d_rdata", d_rdata, 32'd0);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h20;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("busy_no_grant", memory_address, 32'd0);
    stall = 1'b0;
    m = cyc;
    expectAck(PORT_D, 32'hDEAD_BEEF, 1'b0, m + 9);
    waitAck(PORT_D, 25, 1'b1);

    // Memory that never becomes ready.
    stall = 1'b1;
    applyStimulus(PORT_IF, 1'b0, 32'h10, 32'h0, n);
`ifdef MEM_ARB_TIMEOUT_EN
    expectAck(PORT_IF, 32'h0, 1'b1, n + 17);
    waitAck(PORT_IF, 30, 1'b1);
    stall = 1'b0;
    repeat (10) @(posedge clk);
`else
    repeat (30) @(posedge clk);
    #1;
    checkOutput("stuck_addr", memory_address, 32'h10);
    checkOutput("stuck_start", {31'b0, memory_start}, 32'd0);
    checkOutput("stuck_if_ack", {31'b0, if_ack}, 32'd0);
    reset_n = 1'b0;
    if_req  = 1'b0;
    stall   = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b1;
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
